mul8_shift_add: RTL and testbench
=================================

Name: mul8_shift_add

Overview:
- Sequential unsigned shift-and-add multiplier with valid/ready handshakes on both sides.
- Takes two OP_W-bit operands and produces a 2*OP_W-bit product.
- Uses one instance of the team's 16-bit ripple adder (fulladder16, carry-in internally 0) as its only adder: one partial-product add per cycle.
- Sits directly upstream of that adder: drives its A/B inputs from internal registers and captures its S output every cycle.

Parameters:
- OP_W, 8, operand width in bits. Legal range 2..8 (2*OP_W ≤ 16). Operands are zero-extended to 16 bits at the adder inputs.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present on a/b.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  OP_W  multiplicand, unsigned.
- b  input  OP_W  multiplier, unsigned.
- out_valid  output  1  product valid (high only in DONE).
- out_ready  input  1  consumer accepts product.
- product  output  2*OP_W  result; held stable while out_valid=1.
- busy  output  1  high in RUN.

Behaviour:
- States: IDLE, RUN, DONE. Internal registers:
  - mcand: 16-bit multiplicand, shifted left.
  - mplier: OP_W-bit multiplier, shifted right.
  - acc: 16-bit accumulator.
  - cnt: $clog2(OP_W+1) bits.
- Reset (rst_n low, asynchronous): state=IDLE, acc/mcand/mplier/cnt=0, product=0, out_valid=0, busy=0.
  - in_ready=1 whenever state=IDLE, including while rst_n is low.
- IDLE:
  - in_ready=1.
  - On edge with in_valid=1: mcand<={zeros,a}, mplier<=b, acc<=0, cnt<=0, go to RUN.
- RUN, every cycle:
  - Adder A=acc, B=mcand.
  - If mplier[0]=1, acc<=S; else acc holds.
  - mcand<=mcand<<1; mplier<=mplier>>1; cnt<=cnt+1.
  - When cnt==OP_W-1 this cycle, go to DONE. acc after this edge is the final product.
- DONE:
  - out_valid=1; product=acc[2*OP_W-1:0].
  - On edge with out_ready=1, go to IDLE; out_valid drops next cycle.
  - Product and out_valid hold indefinitely while out_ready=0.
- Latency: operands accepted at edge k give out_valid=1 after edge k+OP_W (8 cycles at default).
  - Throughput: one product per OP_W+2 cycles when out_ready is held high.
- in_valid is ignored outside IDLE. No new operands are accepted in the same cycle DONE hands off; IDLE always lasts at least one cycle.
- Adder Cout must be 0 in every RUN cycle, because the product fits in 16 bits. It is unused; a simulation assertion checks it.
- a=0 or b=0: product=0 after the normal latency.
- Maximum operands: a=b=2^OP_W-1 gives (2^OP_W-1)^2 with no wrap.
- Reset mid-RUN or mid-DONE: immediate return to IDLE. The partial result is discarded and out_valid=0 with no glitch to 1.
- product is registered (driven from acc), never combinational from S.

Optional Feature:
- Macro: MUL_EARLY_TERM_EN.
- Defined:
  - On accept, if b==0, go directly to DONE with acc=0, so latency is 1.
  - In RUN, go to DONE after any cycle whose shifted mplier becomes 0.
  - Latency = index of the most-significant set bit of b, plus 1 (b=1 gives 1 cycle; b=8'h80 gives 8).
  - Results are identical to the non-early-termination build.
- Undefined: fixed OP_W-cycle latency regardless of b. cnt alone controls termination.

Test Plan:
- Reset, then a=13, b=11, out_ready=1.
  - Product=16'h008F.
  - out_valid rises exactly 8 cycles after accept (without MUL_EARLY_TERM_EN).
  - in_ready=0 during RUN.
- a=8'hFF, b=8'hFF → product=16'hFE01, Cout never 1. Also a=0, b=8'hA5 → 16'h0000 after 8 cycles.
- Backpressure: a=200, b=3, out_ready=0 for 5 cycles after out_valid.
  - Product stays 16'h0258 and out_valid stays 1.
  - in_valid pulses are ignored.
  - Block returns to IDLE the cycle after out_ready=1.
- Back-to-back: in_valid and out_ready held high with pairs (1,1), (2,128), (255,1).
  - Products 1, 256, 255 in order.
  - Each transaction takes 10 cycles.
- Reset mid-op: assert rst_n=0 asynchronously 4 cycles into RUN with a=7, b=9.
  - out_valid=0 and product=0 immediately.
  - Next transaction a=7, b=9 yields 16'h003F.
- With MUL_EARLY_TERM_EN: b=1 → latency 1; b=0 → latency 1, product 0; b=8'h80, a=2 → latency 8, product 16'h0100.

Source files
------------

// File: rtl/mul8_shift_add_if.sv
// Handshake bundle for the shift-and-add multiplier: an operand channel in, a product channel out.
// The master side is the producer/consumer; the slave side is the multiplier itself.
interface mul8_shift_add_if #(
    parameter int OP_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic              out_valid;
    logic              out_ready;
    logic [2*OP_W-1:0] product;
    logic              busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/mul8_shift_add.sv
// Sequential unsigned shift-and-add multiplier built around one 16-bit ripple adder.
// Optional macro MUL_EARLY_TERM_EN ends RUN as soon as the remaining multiplier bits are zero.

module fulladder16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] s,
    output logic        cout
);
    logic [16:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < 16; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[16];
endmodule

// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one partial-product add per cycle, busy=1
// DONE  | product presented, out_valid=1 until out_ready
module mul8_shift_add #(
    parameter int OP_W = 8
) (
    input logic              clk,
    input logic              rst_n,
    mul8_shift_add_if.slave  bus
);
    localparam int CNT_W = $clog2(OP_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nx;

    logic [15:0]       mcand;
    logic [OP_W-1:0]   mplier;
    logic [15:0]       acc;
    logic [CNT_W-1:0]  cnt;

    logic [15:0]       add_s;
    logic              add_cout;
    logic [OP_W-1:0]   mplier_sh;
    logic              cnt_last;
    logic              run_last;
    logic              start_done;

    fulladder16 u_add (
        .a    (acc),
        .b    (mcand),
        .s    (add_s),
        .cout (add_cout)
    );

    assign mplier_sh = mplier >> 1;
    assign cnt_last  = (cnt == CNT_W'(OP_W - 1));

`ifdef MUL_EARLY_TERM_EN
    // Stop once no set multiplier bits remain; cnt still bounds the run.
    assign run_last   = cnt_last || (mplier_sh == '0);
    assign start_done = (bus.b == '0);
`else
    assign run_last   = cnt_last;
    assign start_done = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_nx = start_done ? DONE : RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (run_last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mcand  <= 16'(bus.a);
                        mplier <= bus.b;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    if (mplier[0]) begin
                        acc <= add_s;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier_sh;
                    cnt    <= cnt + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Product comes straight from the accumulator register, never from the adder sum.
    assign bus.product = acc[2*OP_W-1:0];

    a_no_cout: assert property (@(posedge clk) disable iff (!rst_n) (state == RUN) |-> !add_cout);

endmodule

// File: tb/tb_mul8_shift_add.sv
// Self-checking bench for mul8_shift_add: scoreboard of expected products, latency,
// backpressure, back-to-back throughput and asynchronous reset scenarios.
module tb_mul8_shift_add;
    localparam int OP_W = 8;
    localparam int TMO  = 40;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic [2*OP_W-1:0] sc_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mul8_shift_add_if #(.OP_W(OP_W)) bus ();

    mul8_shift_add #(.OP_W(OP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Edges from the accept edge until out_valid is first visible.
    function automatic int exp_lat(input logic [OP_W-1:0] b);
`ifdef MUL_EARLY_TERM_EN
        // b==0 enters DONE on the accept edge itself (one cycle from in_valid to out_valid).
        if (b == '0) return 0;
        for (int i = OP_W - 1; i >= 0; i--) begin
            if (b[i]) return i + 1;
        end
        return 0;
`else
        return OP_W;
`endif
    endfunction

    task automatic start_op(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
        @(negedge clk);
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        sc_q.push_back((2*OP_W)'(a) * (2*OP_W)'(b));
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.product !== '0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b product=%h required 1 0 0 0000",
                     bus.in_ready, bus.out_valid, bus.busy, bus.product);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        logic [2*OP_W-1:0] e;
        bus.out_ready = 1'b1;
        start_op(8'd13, 8'd11);
        lat = 0;
        while (!bus.out_valid && lat < TMO) begin
            checks++;
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL basic_run_flags: in_ready=%b busy=%b required 0 1", bus.in_ready, bus.busy);
            end
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== exp_lat(8'd11)) begin
            errors++;
            $display("FAIL basic_latency: got %0d required %0d", lat, exp_lat(8'd11));
        end
        e = sc_q.pop_front();
        checks++;
        if (bus.product !== e || e !== 16'h008F) begin
            errors++;
            $display("FAIL basic_product: got %h required %h", bus.product, e);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_handoff: out_valid=%b in_ready=%b required 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_max();
        logic [OP_W-1:0] ta[2] = '{8'hFF, 8'h00};
        logic [OP_W-1:0] tb[2] = '{8'hFF, 8'hA5};
        int lat;
        logic [2*OP_W-1:0] e;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_op(ta[i], tb[i]);
            lat = 0;
            while (!bus.out_valid && lat < TMO) begin
                checks++;
                if (dut.add_cout !== 1'b0) begin
                    errors++;
                    $display("FAIL max_cout: case %0d cout=%b required 0", i, dut.add_cout);
                end
                @(negedge clk);
                lat++;
            end
            checks++;
            if (lat !== exp_lat(tb[i])) begin
                errors++;
                $display("FAIL max_latency: case %0d got %0d required %0d", i, lat, exp_lat(tb[i]));
            end
            e = sc_q.pop_front();
            checks++;
            if (bus.product !== e) begin
                errors++;
                $display("FAIL max_product: case %0d got %h required %h", i, bus.product, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [2*OP_W-1:0] e;
        bus.out_ready = 1'b0;
        start_op(8'd200, 8'd3);
        wait_done(lat);
        e = sc_q[0];
        checks++;
        if (lat !== exp_lat(8'd3) || bus.product !== e) begin
            errors++;
            $display("FAIL bp_first: latency %0d product %h required %0d %h", lat, bus.product, exp_lat(8'd3), e);
        end
        for (int i = 0; i < 5; i++) begin
            bus.a        = 8'd5;
            bus.b        = 8'd5;
            bus.in_valid = (i % 2 == 0);
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.product !== 16'h0258 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d out_valid=%b product=%h in_ready=%b required 1 0258 0",
                         i, bus.out_valid, bus.product, bus.in_ready);
            end
        end
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        void'(sc_q.pop_front());
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b required 0 1 0",
                     bus.out_valid, bus.in_ready, bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_idle: in_ready=%b required 1", bus.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [OP_W-1:0] ta[3] = '{8'd1, 8'd2, 8'd255};
        logic [OP_W-1:0] tb[3] = '{8'd1, 8'd128, 8'd1};
        int acc_cyc[3];
        int lim;
        int lat;
        logic [2*OP_W-1:0] e;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lim = 0;
            while (!bus.in_ready && lim < TMO) begin
                @(negedge clk);
                lim++;
            end
            bus.a        = ta[i];
            bus.b        = tb[i];
            bus.in_valid = 1'b1;
            sc_q.push_back((2*OP_W)'(ta[i]) * (2*OP_W)'(tb[i]));
            acc_cyc[i] = cyc;
            @(negedge clk);
            wait_done(lat);
            e = sc_q.pop_front();
            checks++;
            if (bus.product !== e) begin
                errors++;
                $display("FAIL b2b_product: item %0d got %h required %h", i, bus.product, e);
            end
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (acc_cyc[i+1] - acc_cyc[i] !== exp_lat(tb[i]) + 2) begin
                errors++;
                $display("FAIL b2b_period: item %0d got %0d cycles required %0d",
                         i, acc_cyc[i+1] - acc_cyc[i], exp_lat(tb[i]) + 2);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int lat;
        logic [2*OP_W-1:0] e;
        bus.out_ready = 1'b1;
        start_op(8'd7, 8'd9);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.product !== '0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_run: out_valid=%b product=%h busy=%b in_ready=%b required 0 0000 0 1",
                     bus.out_valid, bus.product, bus.busy, bus.in_ready);
        end
        sc_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        bus.out_ready = 1'b0;
        start_op(8'd7, 8'd9);
        wait_done(lat);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.product !== '0) begin
            errors++;
            $display("FAIL rst_done: out_valid=%b product=%h required 0 0000", bus.out_valid, bus.product);
        end
        sc_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        bus.out_ready = 1'b1;
        start_op(8'd7, 8'd9);
        wait_done(lat);
        e = sc_q.pop_front();
        checks++;
        if (lat !== exp_lat(8'd9) || bus.product !== e || e !== 16'h003F) begin
            errors++;
            $display("FAIL rst_recover: latency %0d product %h required %0d %h", lat, bus.product, exp_lat(8'd9), e);
        end
        @(negedge clk);
    endtask

`ifdef MUL_EARLY_TERM_EN
    task automatic test_early_term();
        logic [OP_W-1:0] ta[3] = '{8'd3, 8'd9, 8'd2};
        logic [OP_W-1:0] tb[3] = '{8'd1, 8'd0, 8'h80};
        int lat;
        logic [2*OP_W-1:0] e;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_op(ta[i], tb[i]);
            wait_done(lat);
            e = sc_q.pop_front();
            checks++;
            if (lat !== exp_lat(tb[i]) || bus.product !== e) begin
                errors++;
                $display("FAIL early_term: case %0d latency %0d product %h required %0d %h",
                         i, lat, bus.product, exp_lat(tb[i]), e);
            end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
`ifdef MUL_EARLY_TERM_EN
        test_early_term();
`endif
        checks++;
        if (sc_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sc_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
